// File: rtl/axi_dma_nd_pkg.sv
// Shared definitions for the N-dimensional DMA burst expander.
// Holds the FSM state encoding, default width constants and the default
// 1D burst / ND request structs used when the top is not given custom types.
package axi_dma_nd_pkg;

   localparam int unsigned DEF_ADDR_WIDTH = 32;
   localparam int unsigned DEF_REP_WIDTH  = 32;
   localparam int unsigned DEF_NUM_DIMS   = 3;
   localparam int unsigned DEF_ID_WIDTH   = 4;
   localparam int unsigned DEF_USER_WIDTH = 1;

   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ISSUE = 1'b1
   } nd_state_e;

   typedef struct packed {
      logic [DEF_ID_WIDTH-1:0]   id;
      logic [DEF_ADDR_WIDTH-1:0] src;
      logic [DEF_ADDR_WIDTH-1:0] dst;
      logic [DEF_ADDR_WIDTH-1:0] num_bytes;
      logic [3:0]                src_cache;
      logic [3:0]                dst_cache;
      logic [1:0]                src_burst;
      logic [1:0]                dst_burst;
      logic [DEF_USER_WIDTH-1:0] src_user;
      logic [DEF_USER_WIDTH-1:0] dst_user;
      logic                      decouple_rw;
      logic                      deburst;
   } burst_req_def_t;

   typedef struct packed {
      logic [DEF_REP_WIDTH-1:0]  reps;
      logic [DEF_ADDR_WIDTH-1:0] src_strd;
      logic [DEF_ADDR_WIDTH-1:0] dst_strd;
   } nd_dim_def_t;

   // d_req[0] is the innermost outer dimension.
   typedef struct packed {
      burst_req_def_t                   burst_req;
      nd_dim_def_t [DEF_NUM_DIMS-2:0]   d_req;
   } nd_req_def_t;

endpackage

// File: rtl/axi_dma_nd_ext_dim_cnt.sv
// One outer dimension of the ND walker: repetition counter with wrap.
// Ports: clk_i/rst_ni; inc_i carry-in (advance this dimension); reps_i
// repetition count; carry_o asserted when this dimension wraps on inc_i.
module axi_dma_nd_dim_cnt #(
   parameter int unsigned REP_WIDTH = 32
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 inc_i,
   input  logic [REP_WIDTH-1:0] reps_i,
   output logic                 carry_o
);

   logic [REP_WIDTH-1:0] cnt_q, cnt_d;
   logic                 at_last;

   assign at_last = (cnt_q == reps_i - REP_WIDTH'(1));
   assign carry_o = inc_i && at_last;

   always_comb begin
      cnt_d = cnt_q;
      if (inc_i) cnt_d = at_last ? '0 : cnt_q + REP_WIDTH'(1);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) cnt_q <= '0;
      else         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/fifo_v3.sv
// Small synchronous FIFO (non fall-through), head entry visible on data_o.
// Ports: clk_i/rst_ni clock and async active-low reset; push_i/data_i write
// side (ignored when full); pop_i/data_o read side (ignored when empty);
// full_o, empty_o, usage_o occupancy status.
module fifo_v3 #(
   parameter int unsigned DEPTH = 2,
   parameter type         dtype = logic,
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   output logic             full_o,
   output logic             empty_o,
   output logic [CNT_W-1:0] usage_o,
   input  dtype             data_i,
   input  logic             push_i,
   output dtype             data_o,
   input  logic             pop_i
);

   dtype             mem_q [DEPTH];
   logic [PTR_W-1:0] wr_q, rd_q;
   logic [CNT_W-1:0] cnt_q;
   logic             push_ok, pop_ok;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full_o  = (cnt_q == CNT_W'(DEPTH));
   assign empty_o = (cnt_q == '0);
   assign usage_o = cnt_q;
   assign push_ok = push_i && !full_o;
   assign pop_ok  = pop_i && !empty_o;
   assign data_o  = mem_q[rd_q];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         if (push_ok) wr_q <= ptr_inc(wr_q);
         if (pop_ok)  rd_q <= ptr_inc(rd_q);
         cnt_q <= cnt_q + CNT_W'(push_ok) - CNT_W'(pop_ok);
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_ok) mem_q[wr_q] <= data_i;
   end

endmodule

// File: rtl/axi_dma_nd_ext.sv
// ND-to-1D DMA request expander. Queues ND requests and flattens each into
// a stream of 1D bursts, walking the outer dimensions as an odometer.
// Ports: clk_i, rst_ni (async active-low); nd_req_i/nd_req_valid_i/
// nd_req_ready_o request queue input; burst_req_o/burst_req_valid_o/
// burst_req_ready_i flattened burst output; nd_req_done_o one-cycle pulse
// when a request has been fully issued; busy_o while work is pending.
// Optional: AXI_DMA_ND_EXT_STATS_EN adds num_bursts_o, a saturating count
// of accepted bursts.
//
// state    | meaning
// ST_IDLE  | request queue empty, nothing to issue
// ST_ISSUE | head request being expanded into bursts
module axi_dma_nd_ext
   import axi_dma_nd_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
   parameter int unsigned REP_WIDTH      = DEF_REP_WIDTH,
   parameter int unsigned NUM_DIMS       = DEF_NUM_DIMS,
   parameter int unsigned REQ_FIFO_DEPTH = 2,
   parameter type         burst_req_t    = burst_req_def_t,
   parameter type         nd_req_t       = nd_req_def_t
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  nd_req_t     nd_req_i,
   input  logic        nd_req_valid_i,
   output logic        nd_req_ready_o,
   output burst_req_t  burst_req_o,
   output logic        burst_req_valid_o,
   input  logic        burst_req_ready_i,
   output logic        nd_req_done_o,
   output logic        busy_o
`ifdef AXI_DMA_ND_EXT_STATS_EN
   ,
   output logic [31:0] num_bursts_o
`endif
);

   localparam int unsigned OUTER = NUM_DIMS - 1;
   localparam int unsigned USE_W = $clog2(REQ_FIFO_DEPTH + 1);

   nd_state_e             state_q, state_d;
   nd_req_t               head;
   logic                  q_full, q_empty;
   logic [USE_W-1:0]      q_usage;
   logic                  push, pop, accept, zero_reps, issuing;
   logic [OUTER:0]        carry;
   logic [ADDR_WIDTH-1:0] src_off_q, src_off_d, dst_off_q, dst_off_d;
   logic [ADDR_WIDTH-1:0] src_strd, dst_strd;

   assign nd_req_ready_o = !q_full;
   assign push           = nd_req_valid_i && !q_full;

   fifo_v3 #(
      .DEPTH (REQ_FIFO_DEPTH),
      .dtype (nd_req_t)
   ) i_req_queue (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .full_o  (q_full),
      .empty_o (q_empty),
      .usage_o (q_usage),
      .data_i  (nd_req_i),
      .push_i  (push),
      .data_o  (head),
      .pop_i   (pop)
   );

   always_comb begin
      zero_reps = 1'b0;
      for (int i = 0; i < OUTER; i++) begin
         if (head.d_req[i].reps == '0) zero_reps = 1'b1;
      end
   end

   assign issuing           = (state_q == ST_ISSUE);
   assign burst_req_valid_o = issuing && !zero_reps;
   assign accept            = burst_req_valid_o && burst_req_ready_i;
   assign carry[0]          = accept;

   for (genvar g = 0; g < OUTER; g++) begin : g_dim
      axi_dma_nd_dim_cnt #(
         .REP_WIDTH (REP_WIDTH)
      ) i_dim_cnt (
         .clk_i   (clk_i),
         .rst_ni  (rst_ni),
         .inc_i   (carry[g]),
         .reps_i  (head.d_req[g].reps),
         .carry_o (carry[g+1])
      );
   end

   // Carry out of the outermost dimension marks acceptance of the last burst.
   assign pop           = issuing && (zero_reps || carry[OUTER]);
   assign nd_req_done_o = pop;
   assign busy_o        = issuing || !q_empty;

   // Strides are relative: only the outermost dimension that advanced adds.
   always_comb begin
      src_strd = '0;
      dst_strd = '0;
      for (int i = 0; i < OUTER; i++) begin
         if (carry[i]) begin
            src_strd = head.d_req[i].src_strd;
            dst_strd = head.d_req[i].dst_strd;
         end
      end
   end

   // Offsets from the base restart at zero so the next request begins at its base.
   always_comb begin
      src_off_d = src_off_q;
      dst_off_d = dst_off_q;
      if (carry[OUTER]) begin
         src_off_d = '0;
         dst_off_d = '0;
      end else if (accept) begin
         src_off_d = src_off_q + src_strd;
         dst_off_d = dst_off_q + dst_strd;
      end
   end

   always_comb begin
      burst_req_o     = head.burst_req;
      burst_req_o.src = head.burst_req.src + src_off_q;
      burst_req_o.dst = head.burst_req.dst + dst_off_q;
      if (!issuing) burst_req_o = '0;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (push) state_d = ST_ISSUE;
         ST_ISSUE: if (pop && !push && q_usage == USE_W'(1)) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         src_off_q <= '0;
         dst_off_q <= '0;
      end else begin
         state_q   <= state_d;
         src_off_q <= src_off_d;
         dst_off_q <= dst_off_d;
      end
   end

`ifdef AXI_DMA_ND_EXT_STATS_EN
   logic [31:0] num_bursts_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni)                                num_bursts_q <= '0;
      else if (accept && num_bursts_q != '1)      num_bursts_q <= num_bursts_q + 32'd1;
   end

   assign num_bursts_o = num_bursts_q;
`endif

endmodule

// File: tb/tb_axi_dma_nd_ext.sv
module tb_axi_dma_nd_ext;
   import axi_dma_nd_pkg::*;

   logic           clk;
   logic           rst_n;
   nd_req_def_t    nd_req;
   logic           nd_req_valid;
   logic           nd_req_ready;
   burst_req_def_t burst_req;
   logic           burst_valid;
   logic           burst_ready;
   logic           done;
   logic           busy;
`ifdef AXI_DMA_ND_EXT_STATS_EN
   logic [31:0]    num_bursts;
`endif

   axi_dma_nd_ext dut (
      .clk_i             (clk),
      .rst_ni            (rst_n),
      .nd_req_i          (nd_req),
      .nd_req_valid_i    (nd_req_valid),
      .nd_req_ready_o    (nd_req_ready),
      .burst_req_o       (burst_req),
      .burst_req_valid_o (burst_valid),
      .burst_req_ready_i (burst_ready),
      .nd_req_done_o     (done),
      .busy_o            (busy)
`ifdef AXI_DMA_ND_EXT_STATS_EN
      ,
      .num_bursts_o      (num_bursts)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      bit             zero;
      burst_req_def_t b;
      bit             last;
   } exp_t;

   exp_t sb[$];
   int   acc_cyc[$];
   int   n_vec = 0;
   int   n_err = 0;
   int   n_done = 0;
   int   cyc = 0;
   bit   toggle_en = 0;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] misc(input burst_req_def_t b);
      return {12'b0, b.id, b.num_bytes, b.src_cache, b.dst_cache, b.src_burst,
              b.dst_burst, b.src_user, b.dst_user, b.decouple_rw, b.deburst};
   endfunction

   function automatic nd_req_def_t mk(input logic [3:0] id, input logic [31:0] src,
                                      input logic [31:0] dst, input int r0, input int r1,
                                      input logic [31:0] ss0, input logic [31:0] ss1,
                                      input logic [31:0] ds0, input logic [31:0] ds1);
      nd_req_def_t r;
      r = '0;
      r.burst_req.id          = id;
      r.burst_req.src         = src;
      r.burst_req.dst         = dst;
      r.burst_req.num_bytes   = 32'h40 + 32'(id);
      r.burst_req.src_cache   = id;
      r.burst_req.dst_cache   = ~id;
      r.burst_req.src_burst   = 2'd1;
      r.burst_req.dst_burst   = id[1:0];
      r.burst_req.src_user    = id[0];
      r.burst_req.dst_user    = id[1];
      r.burst_req.decouple_rw = id[2];
      r.burst_req.deburst     = id[3];
      r.d_req[0].reps         = 32'(r0);
      r.d_req[1].reps         = 32'(r1);
      r.d_req[0].src_strd     = ss0;
      r.d_req[1].src_strd     = ss1;
      r.d_req[0].dst_strd     = ds0;
      r.d_req[1].dst_strd     = ds1;
      return r;
   endfunction

   // Odometer over the two outer dimensions; relative strides.
   task automatic sb_push(input nd_req_def_t r);
      exp_t        e;
      logic [31:0] s, d;
      int          r0, r1;
      r0 = int'(r.d_req[0].reps);
      r1 = int'(r.d_req[1].reps);
      if (r0 == 0 || r1 == 0) begin
         e.zero = 1; e.b = '0; e.last = 1;
         sb.push_back(e);
         return;
      end
      s = r.burst_req.src;
      d = r.burst_req.dst;
      for (int j = 0; j < r1; j++) begin
         for (int i = 0; i < r0; i++) begin
            e.zero  = 0;
            e.b     = r.burst_req;
            e.b.src = s;
            e.b.dst = d;
            e.last  = (i == r0 - 1) && (j == r1 - 1);
            sb.push_back(e);
            if (i < r0 - 1) begin
               s = s + r.d_req[0].src_strd;
               d = d + r.d_req[0].dst_strd;
            end else if (j < r1 - 1) begin
               s = s + r.d_req[1].src_strd;
               d = d + r.d_req[1].dst_strd;
            end
         end
      end
   endtask

   task automatic push_req(input nd_req_def_t r);
      nd_req       = r;
      nd_req_valid = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (nd_req_ready) begin
            @(posedge clk); #1;
            nd_req_valid = 1'b0;
            sb_push(r);
            return;
         end
         @(posedge clk); #1;
      end
      nd_req_valid = 1'b0;
      chk("push_timeout", 0, 1);
   endtask

   task automatic wait_drain(input string tag);
      for (int i = 0; i < 300; i++) begin
         if (sb.size() == 0 && !busy) return;
         @(posedge clk); #1;
      end
      chk({tag, "_timeout"}, 0, 1);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
      #1;
      if (toggle_en) burst_ready = !burst_ready;
   end

   // Output monitor / scoreboard consumer, sampling on the falling edge.
   initial begin
      exp_t           e;
      bit             prev_stall;
      burst_req_def_t prev_burst;
      prev_stall = 0;
      prev_burst = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_stall = 0;
         end else begin
            if (prev_stall) begin
               chk("stall_valid", burst_valid, 1);
               chk("stall_stable", burst_req === prev_burst, 1);
            end
            if (burst_valid && burst_ready) begin
               acc_cyc.push_back(cyc);
               if (sb.size() == 0) begin
                  chk("unexpected_burst", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("burst_kind", e.zero, 0);
                  chk("burst_src", burst_req.src, e.b.src);
                  chk("burst_dst", burst_req.dst, e.b.dst);
                  chk("burst_fields", misc(burst_req), misc(e.b));
                  chk("done_on_last", done, e.last);
               end
            end else if (done) begin
               if (sb.size() == 0) begin
                  chk("unexpected_done", 1, 0);
               end else begin
                  e = sb.pop_front();
                  chk("zero_reps_done", e.zero, 1);
               end
            end
            if (done) n_done++;
            prev_stall = burst_valid && !burst_ready;
            prev_burst = burst_req;
         end
      end
   end

   initial begin
      int d0, a0;
      rst_n        = 1'b0;
      nd_req       = '0;
      nd_req_valid = 1'b0;
      burst_ready  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", burst_valid, 0);
      chk("rst_burst", (burst_req == '0), 1);
      chk("rst_done", done, 0);
      chk("rst_busy", busy, 0);
      chk("rst_ready", nd_req_ready, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Single burst, all reps 1.
      d0 = n_done;
      push_req(mk(4'h1, 32'h1000, 32'h2000, 1, 1, 32'h0, 32'h0, 32'h0, 32'h0));
      @(negedge clk);
      chk("first_valid_lat", burst_valid, 1);
      wait_drain("single");
      chk("single_done_cnt", n_done - d0, 1);

      // 3x2 walk with relative strides.
      acc_cyc.delete();
      push_req(mk(4'h2, 32'h0, 32'h8000, 3, 2, 32'h10, 32'h100, 32'h4, 32'h1000));
      wait_drain("walk3x2");
      chk("walk3x2_bursts", acc_cyc.size(), 6);

      // Zero reps: no burst, done the cycle after push.
      acc_cyc.delete();
      d0 = n_done;
      push_req(mk(4'h3, 32'h500, 32'h600, 4, 0, 32'h10, 32'h10, 32'h10, 32'h10));
      @(negedge clk);
      chk("zero_done_lat", done, 1);
      chk("zero_no_valid", burst_valid, 0);
      wait_drain("zero");
      chk("zero_bursts", acc_cyc.size(), 0);
      chk("zero_done_cnt", n_done - d0, 1);

      // Ready toggling with 2x2.
      acc_cyc.delete();
      burst_ready = 1'b1;
      toggle_en   = 1'b1;
      push_req(mk(4'h4, 32'h3000, 32'h4000, 2, 2, 32'h8, 32'h80, 32'h10, 32'h200));
      wait_drain("toggle");
      toggle_en = 1'b0;
      @(posedge clk); #2;
      burst_ready = 1'b1;
      chk("toggle_bursts", acc_cyc.size(), 4);

      // Three queued requests back to back.
      acc_cyc.delete();
      d0 = n_done;
      push_req(mk(4'h5, 32'h100, 32'h200, 2, 1, 32'h20, 32'h0, 32'h40, 32'h0));
      push_req(mk(4'h6, 32'h300, 32'h400, 2, 1, 32'h20, 32'h0, 32'h40, 32'h0));
      push_req(mk(4'h7, 32'h500, 32'h600, 2, 1, 32'h20, 32'h0, 32'h40, 32'h0));
      wait_drain("b2b");
      chk("b2b_bursts", acc_cyc.size(), 6);
      if (acc_cyc.size() == 6) chk("b2b_span", acc_cyc[5] - acc_cyc[0], 5);
      chk("b2b_done_cnt", n_done - d0, 3);

      // Full queue refuses further requests.
      burst_ready = 1'b0;
      push_req(mk(4'h8, 32'hA00, 32'hB00, 2, 1, 32'h4, 32'h0, 32'h4, 32'h0));
      push_req(mk(4'h9, 32'hC00, 32'hD00, 2, 1, 32'h4, 32'h0, 32'h4, 32'h0));
      chk("full_ready_low", nd_req_ready, 0);
      chk("full_busy", busy, 1);
      burst_ready = 1'b1;
      wait_drain("full");
      chk("drained_ready", nd_req_ready, 1);

      // Address arithmetic wraps modulo 2^32.
      push_req(mk(4'hA, 32'hFFFF_FFF0, 32'h10, 2, 2, 32'h20, 32'h8, 32'hFFFF_FFFF, 32'h100));
      wait_drain("wrap");

      // Reset in the middle of a 3x2 request.
      acc_cyc.delete();
      push_req(mk(4'hB, 32'h0, 32'h0, 3, 2, 32'h10, 32'h100, 32'h10, 32'h100));
      for (int i = 0; i < 50 && acc_cyc.size() < 2; i++) @(negedge clk);
      chk("pre_rst_bursts", acc_cyc.size(), 2);
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", burst_valid, 0);
      chk("mid_rst_burst", (burst_req == '0), 1);
      chk("mid_rst_done", done, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ready", nd_req_ready, 1);
      sb.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      a0 = acc_cyc.size();
      repeat (10) @(posedge clk);
      #1;
      chk("post_rst_no_burst", acc_cyc.size(), a0);
      chk("post_rst_busy", busy, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/axi_dma_nd_ext.md
AXI_DMA_ND_EXT -- requirements
Module: axi_dma_nd_ext

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32, address and stride width.
REQ-002 SHALL have parameter REP_WIDTH, default 32, repetition counter width per dimension.
REQ-003 SHALL have parameter NUM_DIMS, default 3, total dimensions (>=2); outer dimensions = NUM_DIMS-1.
REQ-004 SHALL have parameter REQ_FIFO_DEPTH, default 2, ND request queue depth (>=1).
REQ-005 SHALL have type parameters burst_req_t (1D burst: id, src, dst, num_bytes, user/cache/burst per side, decouple_rw, deburst) and nd_req_t (burst_req_t base plus array of NUM_DIMS-1 {reps, src_strd, dst_strd}, index 0 innermost).
REQ-006 clk_i  in  1  single clock; all state on rising edge.
REQ-007 rst_ni  in  1  reset, asynchronous, active-low.
REQ-008 nd_req_i  in  nd_req_t  ND request.
REQ-009 nd_req_valid_i / nd_req_ready_o  in/out  1  request handshake.
REQ-010 burst_req_o  out  burst_req_t  flattened 1D burst.
REQ-011 burst_req_valid_o / burst_req_ready_i  out/in  1  burst handshake.
REQ-012 nd_req_done_o  out  1  one-cycle pulse: current ND request fully issued.
REQ-013 busy_o  out  1  high while queue non-empty or request in progress.

Function
REQ-014 nd_req_ready_o SHALL equal !queue_full; push on valid&ready.
REQ-015 FSM states IDLE, ISSUE; IDLE->ISSUE when queue non-empty; ISSUE->IDLE after last burst accepted with queue then empty.
REQ-016 On entering ISSUE: load all dim counters to 0, current src/dst from base; first burst valid the cycle after request push into empty queue.
REQ-017 burst_req_valid_o SHALL NOT depend combinationally on burst_req_ready_i; burst_req_o stable while valid&!ready.
REQ-018 burst_req_o SHALL carry base fields unchanged except src/dst = current addresses.
REQ-019 On each accepted burst: innermost counter increments; on reaching reps it wraps to 0 and carries outward; addresses += strides of the outermost dimension that incremented (relative stride), modulo 2^ADDR_WIDTH.
REQ-020 Total bursts per request SHALL equal product of all reps; all-reps==1 yields exactly one burst equal to base.
REQ-021 Last burst = all counters at reps-1; its acceptance SHALL pop the queue and pulse nd_req_done_o in the same cycle.
REQ-022 Back-to-back requests SHALL sustain 1 burst/cycle; next request's first burst valid the cycle after previous last acceptance.
REQ-023 Any reps==0: SHALL emit no burst, pop in one cycle, pulse nd_req_done_o.
REQ-024 Push and pop in same cycle with queue full SHALL be refused (ready low); with queue partially full both SHALL occur.

Reset
REQ-025 During reset: burst_req_valid_o=0, burst_req_o='0, nd_req_done_o=0, busy_o=0, nd_req_ready_o=1, queue empty, FSM IDLE, counters/addresses 0.
REQ-026 Reset mid-request SHALL discard in-flight and queued requests without emitting further bursts.

Configuration
REQ-027 Macro AXI_DMA_ND_EXT_STATS_EN: when defined, add output num_bursts_o [31:0], count of accepted bursts since reset, saturating at 0xFFFFFFFF, reset 0; when undefined, port and counter absent, behaviour otherwise identical.

Structure
REQ-028 Package axi_dma_nd_pkg SHALL hold FSM state enum and default width constants.
REQ-029 Sub-module axi_dma_nd_dim_cnt (one dimension: counter, wrap, carry-in/out) instantiated NUM_DIMS-1 times; queue uses fifo_v3.

Verification
REQ-030 reps={1,1}, src=0x1000, dst=0x2000 -> one burst 0x1000/0x2000, done pulse with its acceptance.
REQ-031 reps={3,2}, src_strd={0x10,0x100}, src=0 -> src sequence 0x0,0x10,0x20,0x120,0x130,0x140; done on 6th.
REQ-032 reps={4,0} -> zero bursts, done pulse one cycle after queue non-empty.
REQ-033 burst_req_ready_i toggling 1-0-1 with reps={2,2} -> burst_req_o stable while stalled, 4 bursts, no loss/duplication.
REQ-034 Three queued reps={2,1} requests, ready held 1 -> 6 bursts on 6 consecutive cycles, 3 done pulses.
REQ-035 rst_ni low after 2 of 6 bursts -> outputs at reset values, no further bursts after release.
